// File: rtl/dungeon_nav_engine.sv
// Dungeon navigation engine: command-driven movement over a tile map read
// from an external memory, simple combat (attack / run away), and a fog-of-war
// bitmap revealed in a diamond around the player after every successful move.
module dungeon_nav_engine #(
    parameter int MAP_W     = 20,
    parameter int MAP_H     = 20,
    parameter int REVEAL_R  = 2,
    parameter int START_POS = 50,
    parameter int HP_MAX    = 100,
    parameter int DAMAGE    = 10,
    localparam int AW       = $clog2(MAP_W * MAP_H),
    localparam int HW       = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    input  logic [4:0]    cmd_code,
    output logic          cmd_ready,
    output logic          map_rd,
    output logic [AW-1:0] map_addr,
    input  logic [3:0]    map_data,
    output logic [AW-1:0] pos,
    output logic [HW-1:0] hp,
    output logic          in_combat,
    output logic          dead,
    output logic          no_shroud,
    output logic          done,
    output logic          run_failed,
    input  logic [AW-1:0] fog_addr,
    output logic          fog_bit
);

    localparam int NCELL = MAP_W * MAP_H;
    localparam int RW    = $clog2(MAP_H);
    localparam int CW    = $clog2(MAP_W);

    localparam logic [3:0]  TILE_WALL  = 4'd5;
    localparam logic [3:0]  TILE_ENEMY = 4'd6;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    localparam logic [2:0]  SWEEP_MAX  = 3'(2 * REVEAL_R);
    localparam logic [2:0]  RAD        = 3'(REVEAL_R);

    typedef enum logic [2:0] {
        S_REVEAL,
        S_IDLE,
        S_RD,
        S_EVAL,
        S_EXEC
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [HW-1:0]   hp_q, hp_d;
    logic            in_combat_q, in_combat_d;
    logic            dead_q, dead_d;
    logic            no_shroud_q, no_shroud_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [1:0]      dir_q, dir_d;
    logic            run_fail_q, run_fail_d;
    // Set once the first post-move sweep starts; the sweep after reset stays silent.
    logic            cmd_reveal_q, cmd_reveal_d;
    logic [2:0]      sr_q, sr_d;
    logic [2:0]      sc_q, sc_d;
    logic [NCELL-1:0] fog_q;
    logic [NCELL-1:0] fog_set;

    // Command decode at the accept point
    logic            accept;
    logic            is_move, is_atk, is_run, is_shroud;
    logic            cmd_ignored;
    logic            run_fail_now;
    logic [1:0]      mv_dir;
    logic [1:0]      acc_dir;
    logic            acc_blocked;
    logic            acc_go_rd;
    logic [HW-1:0]   hp_after;
    logic            lfsr_fb;

    // Move target and sweep cell
    logic [RW-1:0]   tgt_row;
    logic [CW-1:0]   tgt_col;
    logic [15:0]     tgt_lin;
    logic [9:0]      cell_r, cell_c;
    logic [2:0]      ar, ac;
    logic            cell_in_bounds;
    logic            cell_in_radius;
    logic            reveal_we;
    logic [15:0]     reveal_lin;
    logic            sweep_last;
    logic            fog_rd;

    // True when moving in direction d from (r,c) would leave the map.
    function automatic logic is_blocked(input logic [1:0] d,
                                        input logic [RW-1:0] r,
                                        input logic [CW-1:0] c);
        logic b;
        case (d)
            2'd0:    b = (c == CW'(MAP_W - 1));
            2'd1:    b = (c == '0);
            2'd2:    b = (r == '0);
            default: b = (r == RW'(MAP_H - 1));
        endcase
        return b;
    endfunction

    // Classify the offered command and decide whether it needs a map read
    always_comb begin
        accept       = (state_q == S_IDLE) && cmd_valid;
        is_move      = (cmd_code >= 5'd1) && (cmd_code <= 5'd4);
        is_atk       = (cmd_code == 5'd5);
        is_run       = (cmd_code == 5'd6);
        is_shroud    = (cmd_code == 5'h10);
        cmd_ignored  = dead_q || (is_move && in_combat_q) ||
                       ((is_atk || is_run) && !in_combat_q);
        run_fail_now = is_run && !cmd_ignored && (lfsr_q[1:0] == 2'd0);
        // codes 1..4 map onto directions 0..3 (R, L, U, D)
        mv_dir       = cmd_code[1:0] - 2'd1;
        acc_dir      = is_move ? mv_dir : lfsr_q[3:2];
        acc_blocked  = is_blocked(acc_dir, row_q, col_q);
        acc_go_rd    = !cmd_ignored && (is_move || (is_run && !run_fail_now)) && !acc_blocked;
        hp_after     = (hp_q > HW'(DAMAGE)) ? (hp_q - HW'(DAMAGE)) : '0;
        lfsr_fb      = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    end

    // Neighbouring tile in the latched direction; only used when not blocked
    always_comb begin
        tgt_row = row_q;
        tgt_col = col_q;
        case (dir_q)
            2'd0:    tgt_col = col_q + CW'(1);
            2'd1:    tgt_col = col_q - CW'(1);
            2'd2:    tgt_row = row_q - RW'(1);
            default: tgt_row = row_q + RW'(1);
        endcase
        tgt_lin = 16'(tgt_row) * 16'(MAP_W) + 16'(tgt_col);
    end

    // Current sweep cell: offsets are stored biased by +R so counters stay unsigned;
    // a negative coordinate shows up as bit 9 set after the subtraction.
    always_comb begin
        cell_r         = 10'(row_q) + 10'(sr_q) - 10'(REVEAL_R);
        cell_c         = 10'(col_q) + 10'(sc_q) - 10'(REVEAL_R);
        ar             = (sr_q >= RAD) ? (sr_q - RAD) : (RAD - sr_q);
        ac             = (sc_q >= RAD) ? (sc_q - RAD) : (RAD - sc_q);
        cell_in_bounds = !cell_r[9] && !cell_c[9] &&
                         (cell_r < 10'(MAP_H)) && (cell_c < 10'(MAP_W));
        cell_in_radius = ({1'b0, ar} + {1'b0, ac}) <= {1'b0, RAD};
        reveal_we      = (state_q == S_REVEAL) && cell_in_bounds && cell_in_radius;
        reveal_lin     = 16'(cell_r) * 16'(MAP_W) + 16'(cell_c);
        sweep_last     = (sr_q == SWEEP_MAX) && (sc_q == SWEEP_MAX);
    end

    // One-hot set mask for the fog bitmap, one comparator per cell
    genvar gi;
    generate
        for (gi = 0; gi < NCELL; gi++) begin : g_fog_set
            assign fog_set[gi] = reveal_we && (reveal_lin == 16'(gi));
        end
    endgenerate

    // Fog bitmap: bits only ever get set, cleared solely by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fog_q <= '0;
        end else begin
            fog_q <= fog_q | fog_set;
        end
    end

    // Fog lookup port; addresses beyond the map read as hidden
    always_comb begin
        fog_rd  = (32'(fog_addr) < NCELL) ? fog_q[fog_addr] : 1'b0;
        fog_bit = no_shroud_q | fog_rd;
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_REVEAL;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REVEAL: if (sweep_last) state_d = S_IDLE;
            S_IDLE:   if (accept) state_d = acc_go_rd ? S_RD : S_EXEC;
            S_RD:     state_d = S_EVAL;
            S_EVAL:   state_d = (map_data == TILE_WALL) ? S_IDLE : S_REVEAL;
            S_EXEC:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs; done lands on the last cycle of whichever path the command took
    always_comb begin
        cmd_ready  = (state_q == S_IDLE);
        map_rd     = (state_q == S_RD);
        done       = (state_q == S_EXEC) ||
                     ((state_q == S_EVAL) && (map_data == TILE_WALL)) ||
                     ((state_q == S_REVEAL) && sweep_last && cmd_reveal_q);
        run_failed = (state_q == S_EXEC) && run_fail_q;
    end

    // Datapath next-state: command effects, move commit, sweep counters, LFSR
    always_comb begin
        row_d        = row_q;
        col_d        = col_q;
        hp_d         = hp_q;
        in_combat_d  = in_combat_q;
        dead_d       = dead_q;
        no_shroud_d  = no_shroud_q;
        lfsr_d       = {lfsr_fb, lfsr_q[15:1]};
        dir_d        = dir_q;
        run_fail_d   = run_fail_q;
        cmd_reveal_d = cmd_reveal_q;
        sr_d         = sr_q;
        sc_d         = sc_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    dir_d      = acc_dir;
                    run_fail_d = run_fail_now;
                    if (!cmd_ignored && is_atk) begin
                        hp_d   = hp_after;
                        dead_d = (hp_after == '0);
                    end
                    if (!cmd_ignored && is_shroud) begin
                        no_shroud_d = ~no_shroud_q;
                    end
                end
            end
            S_EVAL: begin
                if (map_data != TILE_WALL) begin
                    row_d        = tgt_row;
                    col_d        = tgt_col;
                    in_combat_d  = (map_data == TILE_ENEMY);
                    cmd_reveal_d = 1'b1;
                end
            end
            S_REVEAL: begin
                if (sweep_last) begin
                    sr_d = '0;
                    sc_d = '0;
                end else if (sc_q == SWEEP_MAX) begin
                    sc_d = '0;
                    sr_d = sr_q + 3'd1;
                end else begin
                    sc_d = sc_q + 3'd1;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q        <= RW'(START_POS / MAP_W);
            col_q        <= CW'(START_POS % MAP_W);
            hp_q         <= HW'(HP_MAX);
            in_combat_q  <= 1'b0;
            dead_q       <= 1'b0;
            no_shroud_q  <= 1'b0;
            lfsr_q       <= LFSR_SEED;
            dir_q        <= 2'd0;
            run_fail_q   <= 1'b0;
            cmd_reveal_q <= 1'b0;
            sr_q         <= '0;
            sc_q         <= '0;
        end else begin
            row_q        <= row_d;
            col_q        <= col_d;
            hp_q         <= hp_d;
            in_combat_q  <= in_combat_d;
            dead_q       <= dead_d;
            no_shroud_q  <= no_shroud_d;
            lfsr_q       <= lfsr_d;
            dir_q        <= dir_d;
            run_fail_q   <= run_fail_d;
            cmd_reveal_q <= cmd_reveal_d;
            sr_q         <= sr_d;
            sc_q         <= sc_d;
        end
    end

    assign map_addr  = AW'(tgt_lin);
    assign pos       = AW'(16'(row_q) * 16'(MAP_W) + 16'(col_q));
    assign hp        = hp_q;
    assign in_combat = in_combat_q;
    assign dead      = dead_q;
    assign no_shroud = no_shroud_q;

endmodule

// File: tb/tb_dungeon_nav_engine.sv
// Directed bench for dungeon_nav_engine with default parameters (20x20 map,
// radius 2, start 50). Tile memory answers one cycle after map_rd.
`timescale 1ns/1ps
module tb_dungeon_nav_engine;

    localparam int AWT = 9;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cmd_valid = 1'b0;
    logic [4:0]     cmd_code = 5'd0;
    logic           cmd_ready;
    logic           map_rd;
    logic [AWT-1:0] map_addr;
    logic [3:0]     map_data = 4'd0;
    logic [AWT-1:0] pos;
    logic [15:0]    hp;
    logic           in_combat, dead, no_shroud, done, run_failed;
    logic [AWT-1:0] fog_addr = '0;
    logic           fog_bit;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0]  tiles [0:511];
    logic [15:0] lfsr_m;

    dungeon_nav_engine dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
        .cmd_ready(cmd_ready), .map_rd(map_rd), .map_addr(map_addr),
        .map_data(map_data), .pos(pos), .hp(hp), .in_combat(in_combat),
        .dead(dead), .no_shroud(no_shroud), .done(done), .run_failed(run_failed),
        .fog_addr(fog_addr), .fog_bit(fog_bit)
    );

    always #5 clk = ~clk;

    // Tile memory with one-cycle read latency
    always @(posedge clk) begin
        if (map_rd) map_data <= tiles[map_addr];
    end

    // Reference LFSR: x^16+x^14+x^13+x^11+1, seed ACE1, steps every clock
    always @(posedge clk or posedge rst) begin
        if (rst) lfsr_m <= 16'hACE1;
        else     lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
    end

    typedef struct {
        logic [4:0] code;
        int t_addr;
        int t_val;
        int lat;
        int pos;
        int hp;
        int combat;
        int dead;
        int shroud;
        int rd;
        int addr;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic [4:0] code, input int t_addr, input int t_val,
                                input int lat, input int p, input int h, input int c,
                                input int d, input int s, input int rd, input int addr);
        vec_t v;
        v.code = code; v.t_addr = t_addr; v.t_val = t_val; v.lat = lat; v.pos = p;
        v.hp = h; v.combat = c; v.dead = d; v.shroud = s; v.rd = rd; v.addr = addr;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic chk_fog(input int addr, input int exp);
        @(negedge clk);
        fog_addr = AWT'(addr);
        #1;
        chk($sformatf("fog[%0d]", addr), int'(fog_bit), exp);
    endtask

    task automatic wait_ready();
        int g;
        g = 0;
        while (!cmd_ready && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        if (!cmd_ready) chk("ready_timeout", 0, 1);
    endtask

    // Offer one command, follow it to done; report latency and map-read activity
    task automatic issue(input logic [4:0] code, output int lat, output int rd_cnt,
                         output int rd_addr, output int rf);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_code  = code;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_code  = 5'h1F;
        lat = 0; rd_cnt = 0; rd_addr = -1; rf = 0;
        for (int i = 1; i <= 200; i++) begin
            if (map_rd) begin
                rd_cnt++;
                rd_addr = int'(map_addr);
            end
            if (done) begin
                lat = i;
                rf  = int'(run_failed);
                break;
            end
            @(posedge clk); #1;
        end
        if (lat == 0) chk("done_timeout", 0, 1);
    endtask

    // Hold reset, check cleared state, release and time the silent initial sweep
    task automatic reset_and_sweep();
        int cnt;
        int seen_done;
        rst = 1'b1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst.pos", int'(pos), 50);
        chk("rst.hp", int'(hp), 100);
        chk("rst.combat", int'(in_combat), 0);
        chk("rst.dead", int'(dead), 0);
        chk("rst.shroud", int'(no_shroud), 0);
        chk("rst.done", int'(done), 0);
        chk("rst.map_rd", int'(map_rd), 0);
        chk("rst.run_failed", int'(run_failed), 0);
        chk("rst.ready", int'(cmd_ready), 0);
        chk_fog(11, 0);
        chk_fog(51, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cnt = 0;
        seen_done = 0;
        while (!cmd_ready && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
            if (done) seen_done = 1;
        end
        chk("sweep_len", cnt, 25);
        chk("sweep_done", seen_done, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, rdc, rda, rf, g;
        int exp_p;
        int run_tgt [4];
        logic [1:0] d;

        for (int i = 0; i < 512; i++) tiles[i] = 4'd4;
        run_tgt[0] = 52; run_tgt[1] = 50; run_tgt[2] = 31; run_tgt[3] = 71;

        // ---- reset, initial reveal around 50 ----
        reset_and_sweep();
        chk_fog(50, 1);
        chk_fog(30, 1);
        chk_fog(10, 1);
        chk_fog(52, 1);
        chk_fog(29, 1);
        chk_fog(9, 0);

        // ---- first move right: read 51, 2+25 cycles, widened reveal ----
        issue(5'd1, lat, rdc, rda, rf);
        chk("mv1.lat", lat, 27);
        chk("mv1.addr", rda, 51);
        chk("mv1.rd", rdc, 1);
        chk("mv1.pos", int'(pos), 51);
        chk_fog(11, 1);
        chk_fog(49, 1);
        chk_fog(53, 1);
        chk_fog(91, 1);
        chk_fog(9, 0);

        // ---- table of single commands, starting at pos 51 ----
        //           code  taddr tval lat pos  hp  cmb dead shr rd addr
        vq.push_back(mk(5'd2,  -1, 0, 27, 50, 100, 0, 0, 0, 1, 50));
        vq.push_back(mk(5'd1,  51, 5,  2, 50, 100, 0, 0, 0, 1, 51));
        vq.push_back(mk(5'd5,  -1, 0,  1, 50, 100, 0, 0, 0, 0, 0));
        vq.push_back(mk(5'd6,  -1, 0,  1, 50, 100, 0, 0, 0, 0, 0));
        vq.push_back(mk(5'd0,  -1, 0,  1, 50, 100, 0, 0, 0, 0, 0));
        vq.push_back(mk(5'h11, -1, 0,  1, 50, 100, 0, 0, 0, 0, 0));
        vq.push_back(mk(5'd3,  -1, 0, 27, 30, 100, 0, 0, 0, 1, 30));
        vq.push_back(mk(5'd4,  -1, 0, 27, 50, 100, 0, 0, 0, 1, 50));
        vq.push_back(mk(5'd1,  51, 6, 27, 51, 100, 1, 0, 0, 1, 51));
        vq.push_back(mk(5'd2,  -1, 0,  1, 51, 100, 1, 0, 0, 0, 0));
        vq.push_back(mk(5'h10, -1, 0,  1, 51, 100, 1, 0, 1, 0, 0));
        vq.push_back(mk(5'h10, -1, 0,  1, 51, 100, 1, 0, 0, 0, 0));
        for (int k = 1; k <= 10; k++)
            vq.push_back(mk(5'd5, -1, 0, 1, 51, 100 - 10 * k, 1, (k == 10) ? 1 : 0, 0, 0, 0));
        vq.push_back(mk(5'd5,  -1, 0,  1, 51,   0, 1, 1, 0, 0, 0));
        vq.push_back(mk(5'h10, -1, 0,  1, 51,   0, 1, 1, 0, 0, 0));
        vq.push_back(mk(5'd4,  -1, 0,  1, 51,   0, 1, 1, 0, 0, 0));

        foreach (vq[i]) begin
            if (vq[i].t_addr >= 0) tiles[vq[i].t_addr] = 4'(vq[i].t_val);
            issue(vq[i].code, lat, rdc, rda, rf);
            chk($sformatf("v%0d.lat", i), lat, vq[i].lat);
            chk($sformatf("v%0d.rd", i), rdc, vq[i].rd);
            if (vq[i].rd != 0) chk($sformatf("v%0d.addr", i), rda, vq[i].addr);
            chk($sformatf("v%0d.run_failed", i), rf, 0);
            @(posedge clk); #1;
            chk($sformatf("v%0d.pos", i), int'(pos), vq[i].pos);
            chk($sformatf("v%0d.hp", i), int'(hp), vq[i].hp);
            chk($sformatf("v%0d.combat", i), int'(in_combat), vq[i].combat);
            chk($sformatf("v%0d.dead", i), int'(dead), vq[i].dead);
            chk($sformatf("v%0d.shroud", i), int'(no_shroud), vq[i].shroud);
        end

        // ---- combat run-away: forced failure, then a successful escape ----
        reset_and_sweep();
        issue(5'd1, lat, rdc, rda, rf);
        chk("cb.enter_combat", int'(in_combat), 1);
        wait_ready();
        g = 0;
        while (lfsr_m[1:0] != 2'd0 && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        issue(5'd6, lat, rdc, rda, rf);
        chk("runfail.lat", lat, 1);
        chk("runfail.flag", rf, 1);
        chk("runfail.rd", rdc, 0);
        chk("runfail.pos", int'(pos), 51);
        chk("runfail.combat", int'(in_combat), 1);

        wait_ready();
        g = 0;
        while (lfsr_m[1:0] == 2'd0 && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        d = lfsr_m[3:2];
        exp_p = run_tgt[d];
        issue(5'd6, lat, rdc, rda, rf);
        chk("runok.lat", lat, 27);
        chk("runok.flag", rf, 0);
        chk("runok.addr", rda, exp_p);
        chk("runok.pos", int'(pos), exp_p);
        chk("runok.combat", int'(in_combat), 0);

        issue(5'h10, lat, rdc, rda, rf);
        chk("shroud_on.lat", lat, 1);
        chk_fog(0, 1);
        chk_fog(9, 1);
        chk_fog(200, 1);
        chk_fog(399, 1);
        issue(5'h10, lat, rdc, rda, rf);
        chk_fog(0, 0);

        // ---- walk to the top-right corner and bump both edges ----
        reset_and_sweep();
        issue(5'd3, lat, rdc, rda, rf);
        issue(5'd3, lat, rdc, rda, rf);
        for (int k = 0; k < 9; k++) issue(5'd1, lat, rdc, rda, rf);
        @(posedge clk); #1;
        chk("corner.pos", int'(pos), 19);
        issue(5'd1, lat, rdc, rda, rf);
        chk("edge_r.lat", lat, 1);
        chk("edge_r.rd", rdc, 0);
        chk("edge_r.pos", int'(pos), 19);
        issue(5'd3, lat, rdc, rda, rf);
        chk("edge_u.lat", lat, 1);
        chk("edge_u.rd", rdc, 0);
        chk("edge_u.pos", int'(pos), 19);
        issue(5'd4, lat, rdc, rda, rf);
        chk("down_from_top.lat", lat, 27);
        chk("down_from_top.pos", int'(pos), 39);

        // ---- reset mid-sweep after a move ----
        reset_and_sweep();
        cmd_valid = 1'b1;
        cmd_code  = 5'd1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("midsweep.ready", int'(cmd_ready), 0);
        chk("midsweep.pos", int'(pos), 51);
        chk_fog(11, 1);
        reset_and_sweep();
        chk("after_abort.pos", int'(pos), 50);
        chk("after_abort.combat", int'(in_combat), 0);
        chk_fog(51, 1);
        chk_fog(11, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dungeon_nav_engine.md
DUNGEON_NAV_ENGINE -- requirements
Module: dungeon_nav_engine

Interface
REQ-001 Parameter MAP_W, default 20, map columns (2..64).
REQ-002 Parameter MAP_H, default 20, map rows (2..64).
REQ-003 Parameter REVEAL_R, default 2, fog reveal radius, Manhattan distance (0..3).
REQ-004 Parameter START_POS, default 50, reset position as linear index row*MAP_W+col.
REQ-005 Parameter HP_MAX, default 100, reset hit points; parameter DAMAGE, default 10, HP lost per attack.
REQ-006 Derived AW = clog2(MAP_W*MAP_H); HW = 16.
REQ-007 clk  in  1  single clock, all state on rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 cmd_valid  in  1  command offered.
REQ-010 cmd_code  in  5  1 right, 2 left, 3 up, 4 down, 5 attack, 6 run, 0x10 shroud toggle; all others no-op.
REQ-011 cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid&cmd_ready.
REQ-012 map_rd/map_addr  out  1/AW  tile read request; map_data (in, 4) valid exactly one cycle after map_rd.
REQ-013 pos  out  AW  current position; hp  out  HW  hit points.
REQ-014 in_combat, dead, no_shroud  out  1 each  status flags.
REQ-015 done  out  1  one-cycle pulse on the final cycle of every accepted command; run_failed  out  1  pulse coincident with done.
REQ-016 fog_addr  in  AW; fog_bit  out  1  combinational: revealed bit at fog_addr, or 1 when no_shroud.

Function
REQ-017 Tile codes: 5 WALL, 6 ENEMY; all others passable, no effect.
REQ-018 States: REVEAL, IDLE, RD, EVAL, EXEC.
REQ-019 IDLE: accept -> RD for codes 1-4 and for code 6 when run succeeds; -> EXEC otherwise.
REQ-020 Target for direction d: right blocked if col==MAP_W-1, left if col==0, up if row==0, down if row==MAP_H-1; blocked target -> EXEC, no map read.
REQ-021 RD: map_rd=1, map_addr=target, one cycle -> EVAL.
REQ-022 EVAL: map_data==WALL -> pos unchanged, -> IDLE with done; else pos<=target, in_combat<=(map_data==ENEMY), -> REVEAL.
REQ-023 Codes 1-4 while in_combat, codes 5/6 while !in_combat, any code while dead: no effect, EXEC -> IDLE with done.
REQ-024 Attack: hp<=hp-DAMAGE saturating at 0; dead<=1 when result is 0; in_combat unchanged.
REQ-025 Run: 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), seed 16'hACE1, advances every clk; sampled at accept; lfsr[1:0]==0 -> fail: run_failed pulse, no move; else direction lfsr[3:2] (0 R,1 L,2 U,3 D) via REQ-020..022.
REQ-026 Code 0x10: no_shroud<=~no_shroud, one EXEC cycle.
REQ-027 REVEAL: sweep offsets (dr,dc) over [-R,R]^2, row-major, one per cycle, (2R+1)^2 cycles; set bit if in bounds and |dr|+|dc|<=R; done pulses on last sweep cycle; -> IDLE.
REQ-028 Latencies (accept to done): blocked/non-move 1 cycle; wall 2 cycles; successful move 2+(2R+1)^2 cycles.
REQ-029 cmd_valid outside IDLE ignored, not queued; cmd_code sampled only at accept.

Reset
REQ-030 rst asserted: pos=START_POS, hp=HP_MAX, in_combat=dead=no_shroud=0, done=run_failed=map_rd=0, fog bitmap all 0, LFSR=seed, state=REVEAL.
REQ-031 After rst release, initial reveal sweep around START_POS; cmd_ready rises after (2R+1)^2 cycles; no done pulse for this sweep.
REQ-032 rst mid-command aborts immediately; no done pulse.

Verification
REQ-033 Defaults, all tiles 4: reset, cmd 1 -> map_addr 51, pos 51 after 2+25 cycles; fog bits 11,49,53,91 set, 9 unset.
REQ-034 Tile 51=WALL: cmd 1 -> pos stays 50, done 2 cycles after accept, no REVEAL.
REQ-035 pos 19 (top-right): cmd 1 and cmd 3 -> no map_rd, done after 1 cycle, pos 19.
REQ-036 Tile 51=ENEMY: cmd 1 -> in_combat=1; cmd 2 ignored; 10 attacks -> hp 0, dead=1; attack 11 -> hp stays 0.
REQ-037 In combat, force LFSR[1:0]=0 -> run_failed and done same cycle, pos unchanged; cmd 0x10 -> fog_bit=1 at every address.
REQ-038 Assert rst during REVEAL after a move -> all REQ-030 values, fog cleared, fresh sweep at START_POS.
